// File: rtl/posit_normalizer.sv
// Posit normaliser: shifts an un-normalised adder mantissa until its MSB is set,
// trading exponent/regime per shift. Define POSIT_NORMALIZER_FAST_NORM_EN for a single-cycle LZC + barrel shift.
module posit_normalizer #(
  parameter int WIDTH = 7,
  parameter int EN    = 1,
  parameter int W_REG = $clog2(WIDTH),
  parameter int W_EXP = $clog2(WIDTH),
  parameter int W_MAN = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_MAN-1:0] in_mantissa,
  input  logic [W_REG-1:0] in_regime,
  input  logic [W_EXP-1:0] in_exponent,
  input  logic             in_negate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [W_REG-1:0] out_regime,
  output logic [W_EXP-1:0] out_exponent,
  output logic [W_MAN-1:0] out_mantissa,
  output logic             out_zero,
  output logic             out_underflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer occurs on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE data is frozen until out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [W_REG-1:0] REG_MIN = {1'b1, {(W_REG-1){1'b0}}};

  state_t           state_q;
  logic [W_MAN-1:0] man_q;
  logic [W_REG-1:0] reg_q;
  logic [EN-1:0]    exp_q;
  logic             sign_q;
  logic             zero_q;
  logic             unf_q;

  logic [W_REG-1:0] cap_reg;
  logic [EN-1:0]    cap_exp;
  logic             cap_unf;

  logic [W_MAN-1:0] step_man;
  logic [W_REG-1:0] step_reg;
  logic [EN-1:0]    step_exp;
  logic             step_unf;
  logic             step_done;

  // Only the sign and the low EN bits of the incoming exponent carry information.
  logic unused_exp_bits;
  assign unused_exp_bits = ^in_exponent[W_EXP-2:EN];

  // A negative interim exponent borrows one regime step; at the regime floor it saturates instead.
  always_comb begin
    cap_reg = in_regime;
    cap_exp = in_exponent[EN-1:0];
    cap_unf = 1'b0;
    if (in_exponent[W_EXP-1]) begin
      if (in_regime == REG_MIN) begin
        cap_exp = '0;
        cap_unf = 1'b1;
      end else begin
        cap_reg = in_regime - 1'b1;
      end
    end
  end

`ifdef POSIT_NORMALIZER_FAST_NORM_EN
  localparam int VW  = W_REG + EN;
  localparam int LZW = $clog2(W_MAN);
  localparam int CW  = ((VW > LZW) ? VW : LZW) + 1;

  logic [LZW-1:0] lz;
  logic [VW-1:0]  v_cur;
  logic [VW-1:0]  avail;
  logic [VW-1:0]  v_new;
  logic [CW-1:0]  shamt;

  // {regime, exponent} is one signed scale; avail counts the shifts left before the floor.
  always_comb begin
    lz = '0;
    for (int i = 0; i < W_MAN; i++) begin
      if (man_q[i]) lz = LZW'(W_MAN - 1 - i);
    end
    v_cur    = {reg_q, exp_q};
    avail    = v_cur ^ {1'b1, {(VW-1){1'b0}}};
    step_unf = unf_q;
    if (unf_q) begin
      shamt = '0;
    end else if (CW'(lz) > CW'(avail)) begin
      shamt    = CW'(avail);
      step_unf = 1'b1;
    end else begin
      shamt = CW'(lz);
    end
    v_new     = v_cur - VW'(shamt);
    step_man  = man_q << shamt;
    step_reg  = v_new[VW-1:EN];
    step_exp  = v_new[EN-1:0];
    step_done = 1'b1;
  end
`else
  // One bit per cycle; a required regime decrement at the floor freezes everything.
  always_comb begin
    step_man  = man_q << 1;
    step_reg  = reg_q;
    step_exp  = exp_q - 1'b1;
    step_unf  = unf_q;
    step_done = man_q[W_MAN-2];
    if (unf_q || (exp_q == '0 && reg_q == REG_MIN)) begin
      step_man  = man_q;
      step_exp  = exp_q;
      step_unf  = 1'b1;
      step_done = 1'b1;
    end else if (exp_q == '0) begin
      step_reg = reg_q - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      man_q     <= '0;
      reg_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_negate;
            in_ready <= 1'b0;
            if (in_mantissa == '0) begin
              man_q     <= '0;
              reg_q     <= '0;
              exp_q     <= '0;
              zero_q    <= 1'b1;
              unf_q     <= 1'b0;
              state_q   <= DONE;
              out_valid <= 1'b1;
            end else begin
              man_q  <= in_mantissa;
              reg_q  <= cap_reg;
              exp_q  <= cap_exp;
              zero_q <= 1'b0;
              unf_q  <= cap_unf;
`ifdef POSIT_NORMALIZER_FAST_NORM_EN
              state_q <= SHIFT;
`else
              if (in_mantissa[W_MAN-1] && !cap_unf) begin
                state_q   <= DONE;
                out_valid <= 1'b1;
              end else begin
                state_q <= SHIFT;
              end
`endif
            end
          end
        end
        SHIFT: begin
          man_q <= step_man;
          reg_q <= step_reg;
          exp_q <= step_exp;
          unf_q <= step_unf;
          if (step_done) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_sign      = sign_q;
  assign out_regime    = reg_q;
  assign out_exponent  = {{(W_EXP-EN){1'b0}}, exp_q};
  assign out_mantissa  = man_q;
  assign out_zero      = zero_q;
  assign out_underflow = unf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_posit_normalizer.sv
// Bench for posit_normalizer: directed corner cases plus randomized traffic with
// backpressure, checked by a scoreboard fed from a scale-arithmetic reference model.
module tb_posit_normalizer;
  localparam int WIDTH = 7;
  localparam int EN    = 1;
  localparam int W_REG = 3;
  localparam int W_EXP = 3;
  localparam int W_MAN = 7;
  localparam int PW    = 3 + W_REG + W_EXP + W_MAN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W_MAN-1:0] in_mantissa = '0;
  logic [W_REG-1:0] in_regime = '0;
  logic [W_EXP-1:0] in_exponent = '0;
  logic             in_negate = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_sign;
  logic [W_REG-1:0] out_regime;
  logic [W_EXP-1:0] out_exponent;
  logic [W_MAN-1:0] out_mantissa;
  logic             out_zero;
  logic             out_underflow;
  logic [1:0]       dbg_state;

  posit_normalizer #(.WIDTH(WIDTH), .EN(EN), .W_REG(W_REG), .W_EXP(W_EXP), .W_MAN(W_MAN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mantissa(in_mantissa), .in_regime(in_regime), .in_exponent(in_exponent),
    .in_negate(in_negate), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_regime(out_regime), .out_exponent(out_exponent),
    .out_mantissa(out_mantissa), .out_zero(out_zero), .out_underflow(out_underflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  int            lat_q[$];
  int            cap_q[$];
  int            hold_cnt = 0;
  bit            bp_en = 1'b0;

  function automatic logic [PW-1:0] dut_pack();
    return {out_sign, out_zero, out_underflow, out_regime, out_exponent, out_mantissa};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Regime and exponent together form one scale value r*2^EN+e; each leading zero
  // removes one unit of scale, which may not fall below the regime floor.
  function automatic void model(input logic [W_MAN-1:0] m, input int r, input int e,
                                input logic neg, output logic [PW-1:0] pk, output int lat);
    int rr, ee, n, v, avail, sh;
    logic uf;
    logic [W_MAN-1:0] mm;
    logic [W_REG-1:0] r3;
    logic [W_EXP-1:0] e3;
    if (m == 0) begin
      pk  = {neg, 1'b1, 1'b0, {W_REG{1'b0}}, {W_EXP{1'b0}}, {W_MAN{1'b0}}};
      lat = 1;
      return;
    end
    rr = r;
    ee = e;
    if (ee < 0) begin
      rr = rr - 1;
      ee = ee + 2**EN;
    end
    n = 0;
    for (int i = W_MAN - 1; i >= 0 && !m[i]; i--) n++;
    v     = rr * (2**EN) + ee;
    avail = v + (2**(W_REG-1)) * (2**EN);
    uf    = (n > avail);
    sh    = uf ? avail : n;
    v     = v - sh;
    mm    = m << sh;
    ee    = ((v % (2**EN)) + (2**EN)) % (2**EN);
    rr    = (v - ee) / (2**EN);
    r3    = rr[W_REG-1:0];
    e3    = ee[W_EXP-1:0];
    pk    = {neg, 1'b0, uf, r3, e3, mm};
`ifdef POSIT_NORMALIZER_FAST_NORM_EN
    lat = 2;
`else
    lat = uf ? avail + 2 : n + 1;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W_MAN-1:0] m, input logic [W_REG-1:0] r,
                      input logic [W_EXP-1:0] e, input logic neg);
    logic [PW-1:0] pk;
    int lat;
    int guard;
    model(m, int'($signed(r)), int'($signed(e)), neg, pk, lat);
    @(negedge clk); #1;
    in_valid    = 1'b1;
    in_mantissa = m;
    in_regime   = r;
    in_exponent = e;
    in_negate   = neg;
    guard = 0;
    while (!in_ready) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 200) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    exp_q.push_back(pk);
    lat_q.push_back(lat);
    cap_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  // Offer junk while busy; it must never be captured.
  task automatic junk(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      if (!in_ready && !(out_valid && out_ready)) begin
        in_valid    = 1'b1;
        in_mantissa = W_MAN'($urandom);
        in_regime   = W_REG'($urandom);
        in_exponent = W_EXP'($urandom);
        in_negate   = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_random();
    int lzr;
    logic [W_MAN-1:0] m;
    logic [W_REG-1:0] r;
    logic [W_EXP-1:0] e;
    lzr = $urandom_range(0, W_MAN);
    if (lzr == W_MAN) m = '0;
    else m = (W_MAN'(1) << (W_MAN - 1 - lzr)) | (W_MAN'($urandom) & ((W_MAN'(1) << (W_MAN - 1 - lzr)) - 1'b1));
    r = W_REG'($urandom);
    e = W_EXP'($urandom_range(0, 2**EN) - 1);
    if ($signed(e) < 0 && r == {1'b1, {(W_REG-1){1'b0}}}) e = '0;
    send(m, r, e, 1'($urandom));
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(dut_pack()), 32'hffff_ffff);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 32'(cyc - cap_q[0] + 1), 32'(lat_q[0]));
          end
          check("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) begin
            check("result", 32'(dut_pack()), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(cap_q.pop_front());
            seen = 1'b0;
          end else begin
            check("hold_stable", 32'(dut_pack()), 32'(exp_q[0]));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", 32'(dut_pack()), 32'd0);
    rst = 1'b0;

    send(7'b1000000, 3'd1, 3'd1, 1'b0);
    send(7'b0010110, 3'd0, 3'd1, 1'b0);
    send(7'b0000001, 3'b101, 3'd0, 1'b0);
    send(7'b0000000, 3'd2, 3'd1, 1'b1);
    hold_cnt = 8;
    send(7'b1100000, 3'd2, 3'b111, 1'b0);
    drain();

    // Reset while the long shift is still in progress discards the result.
    send(7'b0000001, 3'd3, 3'd0, 1'b1);
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    cap_q.delete();
    @(negedge clk); #1;
    check("midshift_rst_in_ready", 32'(in_ready), 32'd1);
    check("midshift_rst_out_valid", 32'(out_valid), 32'd0);
    check("midshift_rst_outputs", 32'(dut_pack()), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_quiet", 32'(out_valid), 32'd0);

    bp_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      send_random();
      junk($urandom_range(0, 4));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/posit_normalizer.md
POSIT_NORMALIZER -- requirements
Module: posit_normalizer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 7, posit width; EN, default 1, exponent field bits; W_REG, default $clog2(WIDTH), signed regime width; W_EXP, default $clog2(WIDTH), signed exponent width; W_MAN, default WIDTH, mantissa width with hidden bit at MSB.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  upstream adder result valid.
REQ-005 in_ready  output  1  block can accept a result.
REQ-006 in_mantissa  input  W_MAN  unsigned un-normalised mantissa sum.
REQ-007 in_regime  input  W_REG  signed interim regime.
REQ-008 in_exponent  input  W_EXP  signed interim exponent; range -1..2^EN-1.
REQ-009 in_negate  input  1  result-negate flag from adder.
REQ-010 out_valid  output  1  normalised result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_sign  output  1  equals captured in_negate.
REQ-013 out_regime  output  W_REG  normalised signed regime.
REQ-014 out_exponent  output  W_EXP  normalised exponent, 0..2^EN-1.
REQ-015 out_mantissa  output  W_MAN  normalised mantissa, MSB=1 unless zero/underflow.
REQ-016 out_zero  output  1  captured mantissa was 0.
REQ-017 out_underflow  output  1  regime saturated at minimum before MSB reached 1.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-019 IDLE: on in_valid, capture all inputs; if in_exponent<0, store exponent+2^EN and regime-1; go to SHIFT, or DONE if mantissa MSB=1 or mantissa=0.
REQ-020 Zero capture: out_zero=1, regime/exponent/mantissa outputs 0, sign as captured.
REQ-021 SHIFT: each cycle shift mantissa left by 1 (LSB fill 0), decrement exponent; exponent 0 wraps to 2^EN-1 with regime-1.
REQ-022 SHIFT exits to DONE in the cycle the shifted mantissa MSB becomes 1.
REQ-023 If a regime decrement is required at regime=-(2^(W_REG-1)), regime and exponent hold, out_underflow=1, go to DONE.
REQ-024 Latency: capture edge plus one cycle per leading zero; out_valid asserts the cycle after the final shift (1 cycle when MSB already set).
REQ-025 DONE: out_valid=1, outputs stable; on out_ready go to IDLE; outputs unchanged while out_ready=0.
REQ-026 in_valid while not IDLE SHALL be ignored; no input data sampled.
REQ-027 Arithmetic SHALL be width-exact: exponent modulo 2^EN, regime signed W_REG, no silent truncation elsewhere.

Reset
REQ-028 rst SHALL force IDLE, in_ready=1, out_valid=0, all data outputs and flags 0, including mid-SHIFT or DONE; the pending result is discarded.

Configuration
REQ-029 Macro POSIT_NORMALIZER_FAST_NORM_EN SHALL select the normaliser.
REQ-030 Defined: SHIFT completes in one cycle via leading-zero count and barrel shift, with identical results, flags and saturation to the iterative form; latency 2 cycles from capture to out_valid for all nonzero inputs.
REQ-031 Undefined: iterative one-bit-per-cycle shift per REQ-021..REQ-024.

Verification (WIDTH=7, EN=1, W_REG=3, W_EXP=3)
REQ-032 mantissa=7'b1000000, regime=1, exponent=1 -> out_valid next cycle; regime=1, exponent=1, mantissa=7'b1000000.
REQ-033 mantissa=7'b0010110, regime=0, exponent=1 -> 2 shifts; mantissa=7'b1011000, regime=-1, exponent=1.
REQ-034 mantissa=7'b0000001, regime=-3, exponent=0 -> regime reaches -4, then underflow=1; regime=-4, exponent=0.
REQ-035 mantissa=0, negate=1 -> out_zero=1, out_sign=1, other fields 0, out_valid after 1 cycle.
REQ-036 exponent=-1, regime=2, mantissa=7'b1100000 -> exponent=1, regime=1; out_ready held low 5 cycles -> outputs stable, in_ready=0; then handshake completes.
REQ-037 rst asserted during SHIFT -> next cycle IDLE, out_valid=0, in_ready=1, outputs 0.
